// File: rtl/fifo_patch_deserializer.sv
// Pops NUM_WORDS consecutive words from a first-word-fall-through FIFO and
// presents them as one packed patch over a valid/ready handshake.
module fifo_patch_deserializer #(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_WORDS  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fifo_empty_n,
  input  logic [DATA_WIDTH-1:0]           fifo_dout,
  output logic                            fifo_deq,
  input  logic                            flush,
  output logic                            patch_valid,
  input  logic                            patch_ready,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] patch_data,
  output logic [$clog2(NUM_WORDS+1)-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]            patch_count
);

  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam logic [WCW-1:0] LAST_SLOT = WCW'(NUM_WORDS - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                state_reg;
  logic                  patch_valid_reg;
  logic [WCW-1:0]        word_cnt_reg;
  logic [CNT_WIDTH-1:0]  patch_count_reg;
  logic [DATA_WIDTH-1:0] slot_reg [NUM_WORDS];

  // rst_n is folded in so the pop strobe is quiet while reset is held.
  assign fifo_deq = rst_n && (state_reg == COLLECT) && fifo_empty_n && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg[gi] <= '0;
        end else if (fifo_deq && (word_cnt_reg == WCW'(gi))) begin
          slot_reg[gi] <= fifo_dout;
        end
      end
      assign patch_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= COLLECT;
      patch_valid_reg <= 1'b0;
      word_cnt_reg    <= '0;
      patch_count_reg <= '0;
    end else if (flush) begin
      // Flush wins over a simultaneous handshake: the held patch is dropped uncounted.
      state_reg       <= COLLECT;
      patch_valid_reg <= 1'b0;
      word_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (fifo_empty_n) begin
            if (word_cnt_reg == LAST_SLOT) begin
              word_cnt_reg    <= '0;
              state_reg       <= HOLD;
              patch_valid_reg <= 1'b1;
            end else begin
              word_cnt_reg <= word_cnt_reg + WCW'(1);
            end
          end
        end
        HOLD: begin
          if (patch_ready) begin
            patch_count_reg <= patch_count_reg + CNT_WIDTH'(1);
            state_reg       <= COLLECT;
            patch_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg       <= COLLECT;
          patch_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign patch_valid = patch_valid_reg;
  assign word_cnt    = word_cnt_reg;
  assign patch_count = patch_count_reg;

endmodule
